// File: rtl/mac_loop_ctrl_pkg.sv
// Shared types and constants for the MAC loop controller.
// Lane order follows the microcode offset slots A, B, C, D.
package mac_loop_ctrl_pkg;

  localparam int OFFS_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;
  localparam int NB_OFFS    = 4;

  localparam int MAC_LOOP_NB_OFFS  = NB_OFFS;
  localparam int MAC_UCODE_A_OFFS  = 0;
  localparam int MAC_UCODE_B_OFFS  = 1;
  localparam int MAC_UCODE_C_OFFS  = 2;
  localparam int MAC_UCODE_D_OFFS  = 3;
  localparam int MAC_LOOP_A        = MAC_UCODE_A_OFFS;
  localparam int MAC_LOOP_B        = MAC_UCODE_B_OFFS;
  localparam int MAC_LOOP_C        = MAC_UCODE_C_OFFS;
  localparam int MAC_LOOP_D        = MAC_UCODE_D_OFFS;

  typedef logic [OFFS_WIDTH-1:0] offs_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [NB_OFFS-1:0][OFFS_WIDTH-1:0] offs_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    VALID,
    DONE
  } loop_ctrl_state_t;

  typedef struct packed {
    cnt_t      inner_len;
    cnt_t      outer_len;
    offs_vec_t inner_stride;
    offs_vec_t outer_stride;
  } ctrl_loop_t;

  typedef struct packed {
    offs_vec_t offs;
    logic      valid;
    logic      done;
    logic      busy;
  } flags_loop_t;

  // A zero length behaves like a single iteration.
  function automatic cnt_t last_idx(input cnt_t len);
    return (len == '0) ? '0 : len - CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mac_loop_ctrl_if.sv
// Control/offset bundle between the MAC FSM and the loop controller.
// The FSM side is master; the loop controller is slave.
interface mac_loop_ctrl_if;
  import mac_loop_ctrl_pkg::*;

  logic      clear_i;
  logic      enable_i;
  cnt_t      inner_len_i;
  cnt_t      outer_len_i;
  offs_vec_t inner_stride_i;
  offs_vec_t outer_stride_i;
  offs_vec_t offs_o;
  logic      valid_o;
  logic      done_o;
  logic      busy_o;

  modport master (
    output clear_i, enable_i,
    output inner_len_i, outer_len_i,
    output inner_stride_i, outer_stride_i,
    input  offs_o, valid_o, done_o, busy_o
  );

  modport slave (
    input  clear_i, enable_i,
    input  inner_len_i, outer_len_i,
    input  inner_stride_i, outer_stride_i,
    output offs_o, valid_o, done_o, busy_o
  );

endinterface

// File: rtl/mac_loop_offs_lane.sv
// One offset lane: current offset plus the base of the current
// outer iteration, advanced by inner or outer strides.
module mac_loop_offs_lane
  import mac_loop_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  inc_inner,
  input  logic  inc_outer,
  input  offs_t inner_stride,
  input  offs_t outer_stride,
  output offs_t offs
);

  offs_t base;
  offs_t base_next;

  assign base_next = base + outer_stride;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      offs <= '0;
      base <= '0;
    end else if (inc_outer) begin
      base <= base_next;
      offs <= base_next;
    end else if (inc_inner) begin
      offs <= offs + inner_stride;
    end
  end

endmodule

// File: rtl/mac_loop_ctrl.sv
// Two-level loop controller producing A/B/C/D address offsets
// for the MAC FSM, one advance per enable pulse.
module mac_loop_ctrl
  import mac_loop_ctrl_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  mac_loop_ctrl_if.slave bus
);

  loop_ctrl_state_t state;
  ctrl_loop_t       cfg;
  cnt_t             inner_cnt;
  cnt_t             outer_cnt;
  logic             valid_q;
  logic             done_q;
  logic             busy_q;
  logic             upd;
  logic             inner_more;
  logic             outer_more;
  logic             inc_inner;
  logic             inc_outer;
  offs_vec_t        offs;
  flags_loop_t      flags;

  assign inner_more = inner_cnt < last_idx(cfg.inner_len);
  assign outer_more = outer_cnt < last_idx(cfg.outer_len);

  // Clear wins over an in-flight update.
  assign upd       = (state == UPDATE) && !bus.clear_i;
  assign inc_inner = upd && inner_more;
  assign inc_outer = upd && !inner_more && outer_more;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cfg       <= '0;
      inner_cnt <= '0;
      outer_cnt <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (bus.clear_i) begin
      state            <= IDLE;
      cfg.inner_len    <= bus.inner_len_i;
      cfg.outer_len    <= bus.outer_len_i;
      cfg.inner_stride <= bus.inner_stride_i;
      cfg.outer_stride <= bus.outer_stride_i;
      inner_cnt        <= '0;
      outer_cnt        <= '0;
      valid_q          <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.enable_i) begin
            state  <= UPDATE;
            busy_q <= 1'b1;
          end
        end
        UPDATE: begin
          state   <= VALID;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          unique case (1'b1)
            inner_more: begin
              inner_cnt <= inner_cnt + CNT_WIDTH'(1);
            end
            !inner_more && outer_more: begin
              inner_cnt <= '0;
              outer_cnt <= outer_cnt + CNT_WIDTH'(1);
            end
            !inner_more && !outer_more: begin
              done_q <= 1'b1;
            end
          endcase
        end
        VALID: begin
          valid_q <= 1'b0;
          state   <= done_q ? DONE : IDLE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NB_OFFS; k++) begin : g_lane
    mac_loop_offs_lane u_lane (
      .clk          (clk_i),
      .rst          (rst_i),
      .clear        (bus.clear_i),
      .inc_inner    (inc_inner),
      .inc_outer    (inc_outer),
      .inner_stride (cfg.inner_stride[k]),
      .outer_stride (cfg.outer_stride[k]),
      .offs         (offs[k])
    );
  end

  always_comb begin
    flags       = '0;
    flags.offs  = offs;
    flags.valid = valid_q;
    flags.done  = done_q;
    flags.busy  = busy_q;
  end

  assign bus.offs_o  = flags.offs;
  assign bus.valid_o = flags.valid;
  assign bus.done_o  = flags.done;
  assign bus.busy_o  = flags.busy;

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// Directed bench for mac_loop_ctrl: table-driven iteration walk
// plus hand-written sequences for drops, clears and wrap.
module tb_mac_loop_ctrl;
  import mac_loop_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mac_loop_ctrl_if bus ();

  mac_loop_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp_a;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_clear(input logic [15:0] il, input logic [15:0] ol,
                          input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ic, input logic [31:0] id,
                          input logic [31:0] oa);
    bus.inner_len_i       = il;
    bus.outer_len_i       = ol;
    bus.inner_stride_i[0] = ia;
    bus.inner_stride_i[1] = ib;
    bus.inner_stride_i[2] = ic;
    bus.inner_stride_i[3] = id;
    bus.outer_stride_i    = '0;
    bus.outer_stride_i[0] = oa;
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
  endtask

  // Pulse enable, return cycles until valid_o (99 on timeout).
  task automatic advance(output int lat);
    bus.enable_i = 1'b1;
    step();
    bus.enable_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 8) begin
      step();
      lat++;
    end
    if (!bus.valid_o) lat = 99;
  endtask

  initial begin
    int lat;
    int vc;
    int last;
    logic [31:0] exp_drop[4];

    bus.clear_i        = 1'b0;
    bus.enable_i       = 1'b0;
    bus.inner_len_i    = '0;
    bus.outer_len_i    = '0;
    bus.inner_stride_i = '0;
    bus.outer_stride_i = '0;

    vecs[0] = '{32'd4,  1'b0};
    vecs[1] = '{32'd8,  1'b0};
    vecs[2] = '{32'd64, 1'b0};
    vecs[3] = '{32'd68, 1'b0};
    vecs[4] = '{32'd72, 1'b0};
    vecs[5] = '{32'd72, 1'b1};

    // Reset
    step();
    step();
    rst = 1'b0;
    check("rst_offs",  64'(bus.offs_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_done",  64'(bus.done_o), 64'd0);
    check("rst_busy",  64'(bus.busy_o), 64'd0);

    // Clear with inner=3 outer=2, A strides 4/64
    do_clear(16'd3, 16'd2, 32'd4, 32'd0, 32'd0, 32'd0, 32'd64);
    check("clr_offs",  64'(bus.offs_o[0]), 64'd0);
    check("clr_valid", 64'(bus.valid_o), 64'd0);
    check("clr_done",  64'(bus.done_o), 64'd0);

    // Full sequence, enables 4 cycles apart
    for (int i = 0; i < 6; i++) begin
      advance(lat);
      check($sformatf("seq%0d_lat", i), 64'(lat), 64'd2);
      check($sformatf("seq%0d_offs", i), 64'(bus.offs_o[0]),
            64'(vecs[i].exp_a));
      check($sformatf("seq%0d_done", i), 64'(bus.done_o),
            64'(vecs[i].exp_done));
      step();
      step();
    end
    check("seq_done_sticky", 64'(bus.done_o), 64'd1);

    // Enable held high: every third cycle a valid
    exp_drop[0] = 32'd1;
    exp_drop[1] = 32'd2;
    exp_drop[2] = 32'd3;
    exp_drop[3] = 32'd3;
    do_clear(16'd4, 16'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.enable_i = 1'b1;
    vc = 0;
    last = -1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (bus.valid_o) begin
        if (vc < 4) begin
          check($sformatf("drop%0d_offs", vc), 64'(bus.offs_o[0]),
                64'(exp_drop[vc]));
          check($sformatf("drop%0d_done", vc), 64'(bus.done_o),
                64'(vc == 3));
        end
        if (last >= 0)
          check($sformatf("drop%0d_gap", vc), 64'(c - last), 64'd3);
        else
          check("drop_first_lat", 64'(c), 64'd2);
        last = c;
        vc++;
      end
    end
    bus.enable_i = 1'b0;
    check("drop_count", 64'(vc), 64'd4);

    // Degenerate lengths
    do_clear(16'd0, 16'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd7);
    advance(lat);
    check("deg_lat",   64'(lat), 64'd2);
    check("deg_done",  64'(bus.done_o), 64'd1);
    check("deg_offs",  64'(bus.offs_o[0]), 64'd0);
    step();
    vc = 0;
    bus.enable_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.valid_o || bus.busy_o) vc++;
    end
    bus.enable_i = 1'b0;
    check("deg_ignored",  64'(vc), 64'd0);
    check("deg_sticky",   64'(bus.done_o), 64'd1);

    // Clear in the UPDATE cycle
    do_clear(16'd3, 16'd2, 32'd4, 32'd0, 32'd0, 32'd0, 32'd64);
    bus.enable_i = 1'b1;
    step();
    bus.enable_i = 1'b0;
    check("mid_busy", 64'(bus.busy_o), 64'd1);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    check("mid_valid", 64'(bus.valid_o), 64'd0);
    check("mid_offs",  64'(bus.offs_o[0]), 64'd0);
    check("mid_busy0", 64'(bus.busy_o), 64'd0);
    step();
    check("mid_novalid", 64'(bus.valid_o), 64'd0);
    advance(lat);
    check("mid_restart", 64'(bus.offs_o[0]), 64'd4);
    step();

    // Clear and enable together
    bus.clear_i  = 1'b1;
    bus.enable_i = 1'b1;
    step();
    bus.clear_i  = 1'b0;
    bus.enable_i = 1'b0;
    check("ce_busy", 64'(bus.busy_o), 64'd0);
    check("ce_offs", 64'(bus.offs_o[0]), 64'd0);
    step();
    check("ce_valid", 64'(bus.valid_o), 64'd0);

    // Lane independence and wrap
    do_clear(16'd4, 16'd1, 32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd0);
    advance(lat);
    step();
    advance(lat);
    check("lane_a", 64'(bus.offs_o[MAC_LOOP_A]), 64'd2);
    check("lane_b", 64'(bus.offs_o[MAC_LOOP_B]), 64'd4);
    check("lane_c", 64'(bus.offs_o[MAC_LOOP_C]), 64'd6);
    check("lane_d", 64'(bus.offs_o[MAC_LOOP_D]), 64'hFFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
